word_collect_x2048: RTL and testbench
=====================================

WORD_COLLECT_X2048 -- requirements
Module: word_collect_x2048

Interface
REQ-001 Parameter W, default 32, SHALL set the word width.
REQ-002 Parameter oW, default 2048, SHALL set the block width; oW SHALL be an integer multiple of W.
REQ-003 Parameter CW, default 7, SHALL set the counter width; 2**CW SHALL be at least oW/W+1.
REQ-004 iClk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 iRstn  input  1  SHALL be the reset, synchronous and active-low.
REQ-006 iClear  input  1  SHALL abort collection, synchronous, active-high.
REQ-007 iWordValid  input  1  SHALL flag that the upstream word is valid.
REQ-008 iWord  input  W  SHALL carry the upstream word.
REQ-009 oWordReady  output  1  SHALL flag that a word can be accepted.
REQ-010 oBlockValid  output  1  SHALL flag that a complete block is presented.
REQ-011 iBlockReady  input  1  SHALL be the consumer's acknowledge of the block.
REQ-012 oBlock  output  oW  SHALL carry the assembled block.
REQ-013 oWordCount  output  CW  SHALL report the number of words accepted into the current block.

Function
REQ-014 The block SHALL have two states: COLLECT and FULL.
REQ-015 In COLLECT, oWordReady SHALL be 1 and oBlockValid SHALL be 0.
REQ-016 In FULL, oWordReady SHALL be 0 and oBlockValid SHALL be 1.
REQ-017 A word SHALL be accepted only in a cycle where iWordValid and oWordReady are both 1.
REQ-018 On acceptance, the buffer SHALL shift right by W bits: buf[oW-W-1:0] <= buf[oW-1:W] and buf[oW-1:oW-W] <= iWord.
REQ-019 As a consequence of REQ-018, the first accepted word SHALL end at oBlock[W-1:0] and the last at oBlock[oW-1:oW-W], matching the LSW-first order of the word-serial unloader.
REQ-020 On acceptance, oWordCount SHALL increment by 1.
REQ-021 The state SHALL move COLLECT->FULL on the edge that accepts word number oW/W (count oW/W-1 -> oW/W); oBlockValid SHALL rise the following cycle.
REQ-022 In FULL, oWordCount SHALL hold oW/W and the buffer SHALL hold its value.
REQ-023 A FULL cycle with iBlockReady=1 SHALL move the state to COLLECT and set oWordCount to 0; the buffer SHALL NOT be cleared.
REQ-024 No word SHALL be accepted in the handoff cycle of REQ-023, so sustained throughput is oW/W+1 cycles per block.
REQ-025 oBlock SHALL equal the buffer when oBlockValid=1 and SHALL be all zeros otherwise.
REQ-026 iBlockReady in COLLECT SHALL be ignored.
REQ-027 iWordValid in FULL SHALL be ignored and the word not consumed; upstream SHALL hold the word until oWordReady=1.
REQ-028 iClear=1 SHALL, in either state, force COLLECT, oWordCount=0 and buffer=0, overriding same-cycle word acceptance and block handoff; any pending block SHALL be discarded.
REQ-029 A partial block SHALL never be presented; oBlockValid SHALL require exactly oW/W accepted words since the last reset, clear or handoff.
REQ-030 iWord SHALL be captured without gating logic that depends on iWord's value; only the handshake of REQ-017 qualifies it.

Reset
REQ-031 iRstn=0 at a rising edge SHALL force state COLLECT, buffer=0 and oWordCount=0, taking priority over iClear and all handshakes.
REQ-032 During and after reset, outputs SHALL be oWordReady=1, oBlockValid=0, oBlock=0 and oWordCount=0.
REQ-033 Reset asserted mid-block or in FULL SHALL discard all collected data with no further output.

Verification
REQ-034 Scenario: after reset, feed 64 back-to-back words with iWord=k (k=0..63) and iBlockReady=0.
- Required: oBlockValid=1 one cycle after word 63.
- Required: oBlock[31:0]=0 and oBlock[2047:2016]=63.
- Required: oWordCount=64 and oWordReady=0.
REQ-035 Scenario: in FULL, hold iBlockReady=0 for 10 cycles with iWordValid=1, then pulse iBlockReady.
- Required: block stable and no word consumed during the 10 cycles.
- Required: next cycle oBlockValid=0, oBlock=0, oWordCount=0, oWordReady=1.
REQ-036 Scenario: feed 64 words with iWordValid toggling randomly.
- Required: oBlock holds the accepted words in order; cycles with iWordValid=0 are not counted.
REQ-037 Scenario: after 20 words, assert iClear together with iWordValid=1, then feed 64 words of 0xA5A5A5A5.
- Required: oWordCount=0 after the clear.
- Required: the block is all 0xA5A5A5A5 and no earlier data survives.
REQ-038 Scenario: assert iRstn=0 while oBlockValid=1.
- Required: next cycle oBlockValid=0, oBlock=0, oWordCount=0, oWordReady=1.
REQ-039 Scenario: run two consecutive blocks with iBlockReady tied to 1.
- Required: exactly 65 cycles between oBlockValid pulses, each pulse one cycle wide.

Source files
------------

// File: rtl/word_collect_x2048.sv
// Collects W-bit words, lowest word first, into an oW-bit block.
// Ports: iClk/iRstn (sync, active-low), iClear, word in (iWordValid/iWord/oWordReady),
// block out (oBlockValid/iBlockReady/oBlock), oWordCount.
module word_collect_x2048 #(
  parameter int W  = 32,
  parameter int oW = 2048,
  parameter int CW = 7
) (
  input  logic          iClk,
  input  logic          iRstn,
  input  logic          iClear,
  input  logic          iWordValid,
  input  logic [W-1:0]  iWord,
  output logic          oWordReady,
  output logic          oBlockValid,
  input  logic          iBlockReady,
  output logic [oW-1:0] oBlock,
  output logic [CW-1:0] oWordCount
);

  localparam int NW = oW / W;
  localparam logic [CW-1:0] LAST = CW'(NW - 1);

  localparam logic [0:0] COLLECT = 1'b0;
  localparam logic [0:0] FULL    = 1'b1;

  logic [0:0]    r_state;
  logic [oW-1:0] r_buf;
  logic [CW-1:0] r_cnt;
  logic          w_accept;
  logic          w_handoff;

  assign w_accept  = iWordValid && (r_state == COLLECT);
  assign w_handoff = iBlockReady && (r_state == FULL);

  always_ff @(posedge iClk) begin
    if (!iRstn) begin
      r_state <= COLLECT;
      r_buf   <= '0;
      r_cnt   <= '0;
    end else if (iClear) begin
      r_state <= COLLECT;
      r_buf   <= '0;
      r_cnt   <= '0;
    end else if (w_handoff) begin
      // Buffer is left as-is; oBlock is masked outside FULL.
      r_state <= COLLECT;
      r_cnt   <= '0;
    end else if (w_accept) begin
      // Shift right so the first word ends up in the low bits.
      r_buf <= {iWord, r_buf[oW-1:W]};
      r_cnt <= r_cnt + CW'(1);
      if (r_cnt == LAST)
        r_state <= FULL;
    end
  end

  assign oWordReady  = (r_state == COLLECT);
  assign oBlockValid = (r_state == FULL);
  assign oBlock      = (r_state == FULL) ? r_buf : '0;
  assign oWordCount  = r_cnt;

endmodule

// File: tb/tb_word_collect_x2048.sv
// Self-checking bench for word_collect_x2048.
// Table vectors, directed sequences and a random run against a queue model.
module tb_word_collect_x2048;

  localparam int W  = 32;
  localparam int OW = 2048;
  localparam int CW = 7;
  localparam int NW = OW / W;

  logic          iClk = 1'b0;
  logic          iRstn;
  logic          iClear;
  logic          iWordValid;
  logic [W-1:0]  iWord;
  logic          oWordReady;
  logic          oBlockValid;
  logic          iBlockReady;
  logic [OW-1:0] oBlock;
  logic [CW-1:0] oWordCount;

  word_collect_x2048 #(.W(W), .oW(OW), .CW(CW)) dut (
    .iClk(iClk),
    .iRstn(iRstn),
    .iClear(iClear),
    .iWordValid(iWordValid),
    .iWord(iWord),
    .oWordReady(oWordReady),
    .oBlockValid(oBlockValid),
    .iBlockReady(iBlockReady),
    .oBlock(oBlock),
    .oWordCount(oWordCount)
  );

  always #5 iClk = ~iClk;

  int nvec = 0;
  int nmis = 0;

  // Model: the words accepted into the current block, oldest first.
  logic [W-1:0] q[$];

  function automatic logic [OW-1:0] model_block();
    logic [OW-1:0] b;
    b = '0;
    if (q.size() == NW)
      for (int i = 0; i < NW; i++)
        b[i*W +: W] = q[i];
    return b;
  endfunction

  task automatic chk(input string nm, input logic [OW-1:0] act,
                     input logic [OW-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h (low 64b) expected %h (low 64b)",
               nm, act[63:0], exp[63:0]);
    end
  endtask

  task automatic model_step(input logic rstn, input logic clr,
                            input logic wv, input logic [W-1:0] w,
                            input logic br);
    if (!rstn || clr)
      q.delete();
    else if (q.size() == NW) begin
      if (br) q.delete();
    end else if (wv)
      q.push_back(w);
  endtask

  task automatic cyc(input logic rstn, input logic clr, input logic wv,
                     input logic [W-1:0] w, input logic br);
    iRstn = rstn;
    iClear = clr;
    iWordValid = wv;
    iWord = w;
    iBlockReady = br;
    @(posedge iClk);
    model_step(rstn, clr, wv, w, br);
    #1;
    chk("ready", OW'(oWordReady), OW'(q.size() < NW));
    chk("bvalid", OW'(oBlockValid), OW'(q.size() == NW));
    chk("count", OW'(oWordCount), OW'(q.size()));
    chk("block", oBlock, model_block());
  endtask

  typedef struct {
    logic rstn, clr, wv;
    logic [W-1:0] w;
    logic br;
    logic er, ev;
    logic [CW-1:0] ec;
  } vec_t;

  vec_t tv[8];
  logic [OW-1:0] saved;
  logic [OW-1:0] a5blk;
  int pulses[$];

  initial begin
    iRstn = 1'b0; iClear = 1'b0; iWordValid = 1'b0;
    iWord = '0; iBlockReady = 1'b0;

    tv[0] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 7'd0};
    tv[1] = '{1'b1, 1'b0, 1'b1, 32'h5,        1'b0, 1'b1, 1'b0, 7'd1};
    tv[2] = '{1'b1, 1'b0, 1'b0, 32'hDEAD,     1'b0, 1'b1, 1'b0, 7'd1};
    tv[3] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 7'd1};
    tv[4] = '{1'b1, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, 7'd2};
    tv[5] = '{1'b1, 1'b1, 1'b1, 32'h7,        1'b0, 1'b1, 1'b0, 7'd0};
    tv[6] = '{1'b1, 1'b0, 1'b1, 32'h9,        1'b0, 1'b1, 1'b0, 7'd1};
    tv[7] = '{1'b0, 1'b1, 1'b1, 32'h3,        1'b1, 1'b1, 1'b0, 7'd0};

    for (int i = 0; i < 8; i++) begin
      cyc(tv[i].rstn, tv[i].clr, tv[i].wv, tv[i].w, tv[i].br);
      chk("tv_ready", OW'(oWordReady), OW'(tv[i].er));
      chk("tv_bvalid", OW'(oBlockValid), OW'(tv[i].ev));
      chk("tv_count", OW'(oWordCount), OW'(tv[i].ec));
      chk("tv_block", oBlock, '0);
    end

    // 64 back-to-back words k=0..63
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b0);
    for (int k = 0; k < NW; k++) begin
      chk("pre_full_bvalid", OW'(oBlockValid), '0);
      cyc(1'b1, 1'b0, 1'b1, W'(k), 1'b0);
    end
    chk("s1_bvalid", OW'(oBlockValid), OW'(1));
    chk("s1_lsw", OW'(oBlock[31:0]), '0);
    chk("s1_msw", OW'(oBlock[2047:2016]), OW'(63));
    chk("s1_count", OW'(oWordCount), OW'(64));
    chk("s1_ready", OW'(oWordReady), '0);

    // Stall in FULL with words offered
    saved = oBlock;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b0, 1'b1, $urandom, 1'b0);
      chk("s2_stable", oBlock, saved);
      chk("s2_count", OW'(oWordCount), OW'(64));
    end
    cyc(1'b1, 1'b0, 1'b1, 32'h1234, 1'b1);
    chk("s2_bvalid", OW'(oBlockValid), '0);
    chk("s2_block", oBlock, '0);
    chk("s2_count0", OW'(oWordCount), '0);
    chk("s2_ready", OW'(oWordReady), OW'(1));

    // Random valid toggling until a block completes
    for (int i = 0; i < 400 && q.size() < NW; i++)
      cyc(1'b1, 1'b0, 1'($urandom), $urandom, 1'b0);
    chk("s3_full", OW'(oBlockValid), OW'(1));
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b1);

    // Clear after 20 words, then a block of A5
    for (int k = 0; k < 20; k++)
      cyc(1'b1, 1'b0, 1'b1, $urandom | 32'h1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 32'hFFFF0000, 1'b0);
    chk("s4_count", OW'(oWordCount), '0);
    for (int k = 0; k < NW; k++)
      cyc(1'b1, 1'b0, 1'b1, 32'hA5A5A5A5, 1'b0);
    a5blk = {NW{32'hA5A5A5A5}};
    chk("s4_block", oBlock, a5blk);

    // Reset while a block is presented
    cyc(1'b0, 1'b0, 1'b1, 32'h1, 1'b1);
    chk("s5_bvalid", OW'(oBlockValid), '0);
    chk("s5_block", oBlock, '0);
    chk("s5_count", OW'(oWordCount), '0);
    chk("s5_ready", OW'(oWordReady), OW'(1));

    // Streaming with iBlockReady tied high
    for (int j = 1; j <= 140; j++) begin
      cyc(1'b1, 1'b0, 1'b1, W'(j), 1'b1);
      if (oBlockValid) pulses.push_back(j);
    end
    chk("s6_npulses", OW'(pulses.size()), OW'(2));
    if (pulses.size() == 2)
      chk("s6_gap", OW'(pulses[1] - pulses[0]), OW'(65));

    // Randomized run against the model
    for (int i = 0; i < 3000; i++)
      cyc(($urandom_range(0, 499) != 0), ($urandom_range(0, 199) == 0),
          ($urandom_range(0, 3) != 0), $urandom,
          ($urandom_range(0, 2) == 0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
